// File: rtl/x_delay_line_decode.sv
// rtl/x_delay_line_decode.sv - delay-line snapshot decode with windowed min/max/sum/bubble statistics
module x_delay_line_decode #(
  parameter int WINDOW_LOG2 = 4,
  parameter int WARMUP      = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [31:0]            i_data,
  input  logic                   i_en,
  input  logic                   i_ready,
  output logic [5:0]             o_last,
  output logic                   o_valid,
  output logic [5:0]             o_min,
  output logic [5:0]             o_max,
  output logic [5+WINDOW_LOG2:0] o_sum,
  output logic [WINDOW_LOG2:0]   o_bubbles,
  output logic                   o_ovf
);
  localparam int         W      = WINDOW_LOG2;
  localparam logic [3:0] WARM_N = 4'(WARMUP);
  localparam logic [W:0] WIN_N  = (W+1)'(1) << W;
  localparam logic [5:0] MIN_INIT = 6'd63;

  logic [31:0]  norm;
  logic [5:0]   cnt;
  logic         bub;
  logic         found;

  logic [3:0]   warm_q;
  logic [5:0]   last_q;
  logic         bub_q;
  logic         fold_q;
  logic         warm_done;

  logic [W:0]   acc_n_q,   acc_n_d;
  logic [5:0]   acc_min_q, acc_min_d;
  logic [5:0]   acc_max_q, acc_max_d;
  logic [5+W:0] acc_sum_q, acc_sum_d;
  logic [W:0]   acc_bub_q, acc_bub_d;

  logic [5:0]   res_min_q, res_min_d;
  logic [5:0]   res_max_q, res_max_d;
  logic [5+W:0] res_sum_q, res_sum_d;
  logic [W:0]   res_bub_q, res_bub_d;
  logic         valid_q,   valid_d;
  logic         ovf_q,     ovf_d;

  logic [W:0]   n_inc;
  logic [5:0]   min_nx;
  logic [5:0]   max_nx;
  logic [5+W:0] sum_nx;
  logic [W:0]   bub_nx;
  logic         complete;

  // Flip so propagated taps read 1, then find the first 0 and any 1 beyond it.
  always_comb begin
    norm  = i_data[0] ? i_data : ~i_data;
    cnt   = 6'd32;
    bub   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (!found && !norm[i]) begin
        cnt   = 6'(i);
        found = 1'b1;
      end else if (found && norm[i]) begin
        bub = 1'b1;
      end
    end
  end

  assign warm_done = (warm_q == WARM_N);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      warm_q <= 4'd0;
      last_q <= 6'd0;
      bub_q  <= 1'b0;
      fold_q <= 1'b0;
    end else begin
      if (!warm_done) begin
        warm_q <= warm_q + 4'd1;
      end else begin
        last_q <= cnt;
        bub_q  <= bub;
      end
      fold_q <= warm_done && i_en;
    end
  end

  // Enable travels with its sample, so a disabled sample resets the window.
  always_comb begin
    n_inc    = acc_n_q + (W+1)'(1);
    min_nx   = (last_q < acc_min_q) ? last_q : acc_min_q;
    max_nx   = (last_q > acc_max_q) ? last_q : acc_max_q;
    sum_nx   = acc_sum_q + {{W{1'b0}}, last_q};
    bub_nx   = acc_bub_q + {{W{1'b0}}, bub_q};
    complete = fold_q && (n_inc == WIN_N);

    acc_n_d   = '0;
    acc_min_d = MIN_INIT;
    acc_max_d = 6'd0;
    acc_sum_d = '0;
    acc_bub_d = '0;
    if (fold_q && !complete) begin
      acc_n_d   = n_inc;
      acc_min_d = min_nx;
      acc_max_d = max_nx;
      acc_sum_d = sum_nx;
      acc_bub_d = bub_nx;
    end

    res_min_d = res_min_q;
    res_max_d = res_max_q;
    res_sum_d = res_sum_q;
    res_bub_d = res_bub_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;
    if (complete) begin
      res_min_d = min_nx;
      res_max_d = max_nx;
      res_sum_d = sum_nx;
      res_bub_d = bub_nx;
      valid_d   = 1'b1;
      if (valid_q && !i_ready) begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_n_q   <= '0;
      acc_min_q <= MIN_INIT;
      acc_max_q <= 6'd0;
      acc_sum_q <= '0;
      acc_bub_q <= '0;
      res_min_q <= 6'd0;
      res_max_q <= 6'd0;
      res_sum_q <= '0;
      res_bub_q <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_n_q   <= acc_n_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      acc_sum_q <= acc_sum_d;
      acc_bub_q <= acc_bub_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
      res_sum_q <= res_sum_d;
      res_bub_q <= res_bub_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_last    = last_q;
  assign o_valid   = valid_q;
  assign o_min     = res_min_q;
  assign o_max     = res_max_q;
  assign o_sum     = res_sum_q;
  assign o_bubbles = res_bub_q;
  assign o_ovf     = ovf_q;

endmodule

// File: doc/x_delay_line_decode.md
# x_delay_line_decode

Receive-side companion to the delay-line sensor. It takes the resynchronised 32-tap snapshot every clock and normalises the alternating launch polarity. It decodes how far the launched edge propagated, flags thermometer bubbles, and accumulates min/max/sum statistics over a power-of-two window. Each completed window result is presented on a valid/ready port for the readout logic.

## Interface
- `WINDOW_LOG2`, default 4: window length is 2^WINDOW_LOG2 samples; legal range 1..8.
- `WARMUP`, default 3: number of samples discarded after reset deassertion; legal range 0..15.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low; one clock domain.
- `i_data` in 32: tap snapshot; bit 0 is the launch flop, bit k is after k cells; new snapshot every cycle.
- `i_en` in 1: statistics enable.
- `i_ready` in 1: consumer accepts the result.
- `o_last` out 6: most recent decoded propagation count, 1..32.
- `o_valid` out 1: result registers hold an unconsumed window result.
- `o_min` out 6: minimum count in the window.
- `o_max` out 6: maximum count in the window.
- `o_sum` out 6+WINDOW_LOG2: sum of counts in the window.
- `o_bubbles` out WINDOW_LOG2+1: number of samples in the window with a bubble.
- `o_ovf` out 1: sticky; a result was overwritten before it was accepted.

## Operation
- **Normalise:** `norm = i_data[0] ? i_data : ~i_data`. Launch polarity alternates each cycle, so after normalisation propagated taps read 1.
- **Count:** index of the first 0 in `norm`, scanning from bit 0. If `norm` is all ones, count = 32. Range is 1..32 because `norm[0]` is always 1.
- **Bubble:** set when any 1 appears in `norm` above the first 0.
- **Warm-up:** after reset, the first WARMUP snapshots are not decoded into statistics and `o_last` stays 0. An internal 4-bit counter saturates at WARMUP.
- **Window accumulator:** holds sample count (WINDOW_LOG2+1 bits), running min (init 63), running max (init 0), sum, and bubble count.
  - Each post-warm-up sample with `i_en`=1 is folded in.
  - The sample that brings the window to 2^WINDOW_LOG2 is folded in, the totals (including that sample) are loaded into the result registers, and the accumulator returns to its init values on the same edge.
- **i_en=0:** the accumulator is held at init values, so a partial window is discarded. Decode and `o_last` keep running. Result registers and the handshake are unaffected.
- **Result handshake:**
  - A transfer happens on a rising edge with `o_valid`=1 and `i_ready`=1.
  - While `o_valid`=1, all result outputs are stable until transfer or overwrite.
  - Window completes while `o_valid`=0: load results, `o_valid`←1.
  - Window completes on the same edge as a transfer: load new results, `o_valid` stays 1, `o_ovf` unchanged.
  - Window completes while `o_valid`=1 and `i_ready`=0: overwrite results, `o_ovf`←1.
  - Transfer without a window completing: `o_valid`←0, `o_ovf`←0.
- **Arithmetic:** all unsigned; no saturation is needed because widths cover the maximum (32·2^W fits in 6+W bits).
- **Reset (`i_rst_n`=0, asynchronous, any time including mid-window or while `o_valid`=1):**
  - All outputs go to 0 and the accumulator to init values; the warm-up counter restarts.
  - Pending results are lost and `o_ovf` is cleared.

## Timing
- Decode pipeline is one register stage. A snapshot on `i_data` at edge E produces `o_last` and the bubble flag after E.
- Accumulator and result registers update at E+1. `o_valid` rises after the edge following the last window sample's decode edge, i.e. 2 edges after that snapshot was on `i_data`.
- The first result after reset appears no earlier than WARMUP+2^W+1 edges after reset release (the counted edges are the ones with `i_en`=1).
- Throughput is one sample per cycle with no stall; `i_ready` never back-pressures decode.

## Test plan
- **Alternating polarity:** reset, `i_en`=1, `i_ready`=1, alternate `i_data` 0x000000FF / 0xFFFFFF00 → `o_last`=8 after warm-up; `o_valid` pulses every 16 cycles with `o_min`=8, `o_max`=8, `o_sum`=128, `o_bubbles`=0, `o_ovf`=0.
- **Bubble:** `i_data`=0x000000F7 (bit0=1) → `o_last`=3 and the bubble flag is set; a full window of it gives `o_bubbles`=16, `o_sum`=48.
- **Extremes:** 0xFFFFFFFF, 0x00000000, 0x00000001 and 0xFFFFFFFE → counts 32, 32, 1, 1.
  - A window mixing 15 samples of 1 and one sample of 32 → `o_min`=1, `o_max`=32, `o_sum`=47.
- **Back-pressure:** hold `i_ready`=0 across two window completions → second result overwrites the first and `o_ovf`=1. Assert `i_ready` → transfer, then `o_valid`=0 and `o_ovf`=0.
  - Also complete a window on the same edge as a transfer → `o_valid` stays 1 and `o_ovf`=0.
- **Enable gating:** drop `i_en` for 1 cycle mid-window → partial window discarded, and the next result reflects exactly 16 post-re-enable samples.
- **Reset mid-operation:** assert `i_rst_n`=0 asynchronously mid-window with `o_valid`=1 → all outputs 0 immediately. After release, the first WARMUP snapshots are ignored (`o_last`=0 during that period).
